// File: rtl/dec3_8_strobe.sv
// rtl/dec3_8_strobe.sv - registered 3-to-8 decoder with valid/ready accept and timed one-hot strobes
module dec3_8_strobe #(
  parameter int unsigned HOLD = 4,
  parameter int unsigned GAP  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] i,
  input  logic       v,
  output logic       rdy,
  output logic [7:0] o,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;

  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);
  localparam logic [7:0] GAP_M1  = 8'(GAP - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] o_q, o_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    o_d     = o_q;
    case (state_q)
      S_IDLE: begin
        // i is only looked at under v, so X on i never reaches o
        if (v) begin
          idx_d   = i;
          cnt_d   = HOLD_M1;
          state_d = S_HOLD;
          o_d     = 8'b1 << i;
        end else begin
          o_d = 8'h00;
        end
      end
      S_HOLD: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
          o_d   = 8'b1 << idx_q;
        end else if (GAP != 0) begin
          cnt_d   = GAP_M1;
          state_d = S_GAP;
          o_d     = 8'h00;
        end else begin
          state_d = S_IDLE;
          o_d     = 8'h00;
        end
      end
      S_GAP: begin
        o_d = 8'h00;
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        else               state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
        o_d     = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 3'd0;
      o_q     <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      o_q     <= o_d;
    end
  end

  assign o    = o_q;
  assign rdy  = (state_q == S_IDLE);
  assign busy = ~rdy;

endmodule
